// File: rtl/ov13850_regs_sequencer.sv
// OV13850 register-table sequencer.
// Walks the ROM from address 0 to LAST_ADDR. Each non-zero 24-bit entry
// {reg_addr, reg_data} becomes one SCCB write command. Each all-zero entry
// becomes a settling delay. A command that is nacked or times out is
// re-issued up to MAX_RETRY times. After that the sequencer stops in ERROR.
module ov13850_regs_sequencer #(
    parameter logic [8:0]  LAST_ADDR   = 9'h10E,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned GAP_DELAY   = 500000,
    parameter int unsigned ACK_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        rom_clock_en,
    output logic [8:0]  rom_address,
    input  logic [23:0] rom_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_data,
    input  logic        cmd_done,
    input  logic        cmd_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  fail_address
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ROMWAIT,
        S_DECODE,
        S_ISSUE,
        S_ACKWAIT,
        S_GAP,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [8:0]  r_rom_address;
    logic [15:0] r_cmd_addr;
    logic [7:0]  r_cmd_data;
    logic [31:0] r_count;
    logic [7:0]  r_retry;
    logic        r_done;
    logic        r_error;
    logic [8:0]  r_fail_address;

    logic        w_busy;
    logic        w_rom_en;
    logic        w_cmd_valid;

    // Decoded events shared by the next-state logic and the datapath.
    logic        w_ack_ok;
    logic        w_ack_fail;
    logic        w_can_retry;
    logic        w_entry_zero;
    logic        w_last;

    assign w_ack_ok     = cmd_done && !cmd_nack;
    // A timeout counts as a failure only when no done arrives in the same cycle.
    assign w_ack_fail   = (cmd_done && cmd_nack) || (!cmd_done && (r_count == 32'd0));
    assign w_can_retry  = ({24'd0, r_retry} < MAX_RETRY);
    assign w_entry_zero = ({r_cmd_addr, r_cmd_data} == 24'h000000);
    assign w_last       = (r_rom_address == LAST_ADDR);

    // State register. The reset drops the state-decoded outputs (cmd_valid,
    // rom_clock_en, busy) immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Then every
            // flop in this clock domain samples pre-edge values, which avoids
            // ordering races between always blocks.
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first. A path that
        // leaves a signal unassigned would infer a latch.
        w_next_state = r_state;
        w_busy       = 1'b1;
        w_rom_en     = 1'b0;
        w_cmd_valid  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                w_busy = 1'b0;
                if (start) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_rom_en     = 1'b1;
                w_next_state = S_ROMWAIT;
            end
            S_ROMWAIT: begin
                w_rom_en = 1'b1;
                if (r_count <= 32'd1) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_next_state = w_entry_zero ? S_GAP : S_ISSUE;
            end
            S_ISSUE: begin
                w_cmd_valid = 1'b1;
                if (cmd_ready) w_next_state = S_ACKWAIT;
            end
            S_ACKWAIT: begin
                if (w_ack_ok)        w_next_state = S_NEXT;
                else if (w_ack_fail) w_next_state = w_can_retry ? S_ISSUE : S_ERROR;
            end
            S_GAP: begin
                if (r_count == 32'd0) w_next_state = S_NEXT;
            end
            S_NEXT: begin
                w_next_state = w_last ? S_DONE : S_FETCH;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: ROM address, latched entry, shared down-counter, retry count
    // and the sticky status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: every datapath register has a reset value. After reset the
            // status outputs and the command bus read as zero, not as left-over
            // data.
            r_rom_address  <= '0;
            r_cmd_addr     <= '0;
            r_cmd_data     <= '0;
            r_count        <= '0;
            r_retry        <= '0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_fail_address <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_rom_address <= '0;
                        r_done        <= 1'b0;
                        r_error       <= 1'b0;
                        r_retry       <= '0;
                    end
                end
                S_FETCH: begin
                    r_count <= ROM_LATENCY;
                end
                S_ROMWAIT: begin
                    // The entry is valid ROM_LATENCY cycles after FETCH presented the address.
                    if (r_count <= 32'd1) begin
                        r_cmd_addr <= rom_data[23:8];
                        r_cmd_data <= rom_data[7:0];
                    end else begin
                        r_count <= r_count - 32'd1;
                    end
                end
                S_DECODE: begin
                    if (w_entry_zero) r_count <= GAP_DELAY;
                end
                S_ISSUE: begin
                    if (cmd_ready) r_count <= ACK_TIMEOUT;
                end
                S_ACKWAIT: begin
                    if (w_ack_ok) begin
                        r_retry <= '0;
                    end else if (w_ack_fail) begin
                        if (w_can_retry) begin
                            r_retry <= r_retry + 8'd1;
                        end else begin
                            r_fail_address <= r_rom_address;
                            r_error        <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count - 32'd1;
                    end
                end
                S_GAP: begin
                    if (r_count != 32'd0) r_count <= r_count - 32'd1;
                end
                S_NEXT: begin
                    // The address stops at LAST_ADDR and never wraps.
                    if (w_last) r_done <= 1'b1;
                    else        r_rom_address <= r_rom_address + 9'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_clock_en = w_rom_en;
    assign rom_address  = r_rom_address;
    assign cmd_valid    = w_cmd_valid;
    assign cmd_addr     = r_cmd_addr;
    assign cmd_data     = r_cmd_data;
    assign busy         = w_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign fail_address = r_fail_address;

endmodule

// File: doc/ov13850_regs_sequencer.md
Name: ov13850_regs_sequencer

Overview:
Reader/master for the OV13850 register-table ROM. It walks the 9-bit ROM address space from 0 to LAST_ADDR and decodes each 24-bit entry into {reg_addr[15:0], reg_data[7:0]}. Each non-zero entry is issued as one write command to the SCCB master over a valid/ready + done/nack handshake. All-zero entries are table gaps and insert a settling delay (used after reset and PLL programming). It sits between the camera-control top level (start/status) and the SCCB master.

Parameters:
LAST_ADDR, 9'h10E, final ROM address processed; completing it ends the sequence.
ROM_LATENCY, 2, cycles from rom_address/rom_clock_en presentation to rom_data valid (1..7).
GAP_DELAY, 500000, clock cycles inserted per all-zero entry (10 ms at 50 MHz); 32-bit counter.
ACK_TIMEOUT, 65535, max cycles waiting for cmd_done after cmd accepted; expiry is treated as nack.
MAX_RETRY, 3, re-issues of one entry after nack/timeout before declaring error.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins the sequence from address 0 when IDLE, DONE or ERROR.
rom_clock_en  out  1  ROM read enable.
rom_address  out  9  ROM address.
rom_data  in  24  ROM entry {addr_hi, addr_lo, data}.
cmd_valid  out  1  write command valid to SCCB master.
cmd_ready  in  1  SCCB master accepts command.
cmd_addr  out  16  register address, = rom_data[23:8] latched.
cmd_data  out  8  register data, = rom_data[7:0] latched.
cmd_done  in  1  one-cycle pulse: transaction finished.
cmd_nack  in  1  qualified by cmd_done: slave did not acknowledge.
busy  out  1  high in any state other than IDLE/DONE/ERROR.
done  out  1  sticky; whole table written.
error  out  1  sticky; retries exhausted.
fail_address  out  9  ROM address of the failing entry; valid while error=1.

Behaviour:
- Reset (async): state IDLE; rom_clock_en=0, rom_address=0, cmd_valid=0, cmd_addr=0, cmd_data=0, busy=0, done=0, error=0, fail_address=0, all counters 0.
- States: IDLE, FETCH, ROMWAIT, DECODE, ISSUE, ACKWAIT, GAP, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR + start -> FETCH; clears done, error and the retry count; rom_address<=0. start is ignored in all other states.
- FETCH: rom_clock_en=1 (held through ROMWAIT); go to ROMWAIT with counter=ROM_LATENCY.
- ROMWAIT: decrement; at 0 latch rom_data into cmd_addr/cmd_data and go to DECODE; rom_clock_en<=0.
- DECODE: latched entry == 24'h000000 -> GAP (counter=GAP_DELAY); else -> ISSUE.
- ISSUE: cmd_valid=1 with stable cmd_addr/cmd_data until the cycle cmd_valid&&cmd_ready; next cycle cmd_valid=0, state ACKWAIT, timeout counter=ACK_TIMEOUT.
- ACKWAIT: cmd_done&&!cmd_nack -> NEXT with retry count cleared.
  - cmd_done&&cmd_nack or timeout reaching 0 -> if retry<MAX_RETRY then retry++ and back to ISSUE (same entry, no ROM re-read); else -> ERROR with fail_address=rom_address.
  - cmd_done arriving in ISSUE is ignored.
- GAP: count down to 0 -> NEXT. GAP_DELAY=0 means pass straight through in 1 cycle.
- NEXT: rom_address==LAST_ADDR -> DONE (done=1); else rom_address+1 -> FETCH. No wrap past LAST_ADDR; 9-bit address never exceeds LAST_ADDR.
- Every table entry is read exactly once per run; commands are issued in ascending address order, one outstanding at a time.
- Reset mid-operation aborts immediately; cmd_valid drops asynchronously. The SCCB master is responsible for its own abort.

Test Plan:
- Table {0:0x010301, 1:0x030a00, 2..LAST_ADDR=3: 0x300f11, 0x100001}, ready/done immediate -> 4 commands (0x0103/01, 0x030a/00, 0x300f/11, 0x1000/01) in order; done=1, busy=0, error=0.
- Entry 2 = 0x000000, GAP_DELAY=100 -> no command for entry 2; gap between entry-1 done and entry-3 cmd_valid >= 100 cycles.
- cmd_ready held low 50 cycles -> cmd_valid stays high with constant cmd_addr/cmd_data; exactly one command accepted.
- Entry 1 nacks twice then acks (MAX_RETRY=3) -> 3 issues of 0x030a/00; sequence completes, error=0.
- Entry 1 always nacks -> 4 issues total; error=1, fail_address=1, done=0; a following start restarts at address 0 and clears error.
- cmd_done never returns, ACK_TIMEOUT=20 -> retries after 20 cycles each; ERROR after MAX_RETRY+1 attempts. reset asserted mid-ISSUE -> cmd_valid=0 the same cycle; state IDLE.
